// File: rtl/dfe_ctrl_pkg.sv
// Shared types and tap-word helpers for the DFE load controller, tap bank and tests.
// A tap word is {mantissa, shift} and represents mantissa * 2^shift.
package dfe_ctrl_pkg;

  localparam int unsigned TAP_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_RUN,
    ST_DRAIN
  } state_t;

  function automatic logic [TAP_W/2-1:0] tap_mant(input logic [TAP_W-1:0] w);
    return w[TAP_W-1:TAP_W/2];
  endfunction

  function automatic logic [TAP_W/2-1:0] tap_shift(input logic [TAP_W-1:0] w);
    return w[TAP_W/2-1:0];
  endfunction

endpackage

// File: rtl/dfe_tap_load_ctrl.sv
// DFE sequencer: loads pulse-response taps, checks the main cursor, releases the DFE
// and gates symbols into it; a reload drains the DFE pipeline before rewriting taps.
module dfe_tap_load_ctrl
  import dfe_ctrl_pkg::*;
#(
  parameter int unsigned PULSE_RESPONSE_LENGTH = 4,
  parameter int unsigned SIGNAL_RESOLUTION     = 8,
  parameter int unsigned TAP_WIDTH             = 32,
  parameter int unsigned DRAIN_CYCLES          = 3,
  localparam int unsigned AW = (PULSE_RESPONSE_LENGTH > 1) ? $clog2(PULSE_RESPONSE_LENGTH) : 1,
  localparam int unsigned DW = $clog2(DRAIN_CYCLES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_start,
  input  logic [TAP_WIDTH-1:0]         cfg_data,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  output logic                         cfg_err,
  input  logic [SIGNAL_RESOLUTION-1:0] sym_in,
  input  logic                         sym_in_valid,
  output logic                         sym_in_ready,
  output logic [SIGNAL_RESOLUTION-1:0] dfe_signal_in,
  output logic                         dfe_signal_valid,
  output logic                         dfe_rstn,
  output logic                         tap_we,
  output logic [AW-1:0]                tap_addr,
  output logic [TAP_WIDTH-1:0]         tap_data,
  output logic                         busy
);

  localparam logic [AW-1:0] IDX_LAST   = AW'(PULSE_RESPONSE_LENGTH - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

  state_t        state;
  logic [AW-1:0] idx;
  logic [DW-1:0] drain_cnt;
  logic          main_nz;
  logic          cfg_acc;
  logic          sym_acc;

  assign cfg_acc = cfg_valid && cfg_ready;
  assign sym_acc = sym_in_valid && sym_in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      idx              <= '0;
      drain_cnt        <= '0;
      main_nz          <= 1'b0;
      cfg_ready        <= 1'b0;
      cfg_err          <= 1'b0;
      sym_in_ready     <= 1'b0;
      dfe_signal_in    <= '0;
      dfe_signal_valid <= 1'b0;
      dfe_rstn         <= 1'b0;
      tap_we           <= 1'b0;
      tap_addr         <= '0;
      tap_data         <= '0;
      busy             <= 1'b0;
    end else begin
      tap_we           <= 1'b0;
      dfe_signal_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            state     <= ST_LOAD;
            idx       <= '0;
            cfg_err   <= 1'b0;
            cfg_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          // A restart wins over a word presented in the same cycle.
          if (cfg_start) begin
            idx <= '0;
          end else if (cfg_acc) begin
            tap_we   <= 1'b1;
            tap_addr <= idx;
            tap_data <= cfg_data;
            if (idx == '0) begin
              main_nz <= |cfg_data[TAP_WIDTH-1:TAP_WIDTH/2];
            end
            if (idx == IDX_LAST) begin
              state     <= ST_CHECK;
              cfg_ready <= 1'b0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_CHECK: begin
          busy <= 1'b0;
          if (!main_nz) begin
            cfg_err <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            dfe_rstn     <= 1'b1;
            sym_in_ready <= 1'b1;
            state        <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (sym_acc) begin
            dfe_signal_in    <= sym_in;
            dfe_signal_valid <= 1'b1;
          end
          if (cfg_start) begin
            state        <= ST_DRAIN;
            sym_in_ready <= 1'b0;
            busy         <= 1'b1;
            drain_cnt    <= '0;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            drain_cnt <= '0;
            dfe_rstn  <= 1'b0;
            idx       <= '0;
            cfg_ready <= 1'b1;
            state     <= ST_LOAD;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
